// File: rtl/score_tracker.sv
// rtl/score_tracker.sv - egg score to BCD / 7-segment converter (optional high score via HISCORE_EN)
module score_tracker #(
  parameter int SCORE_W   = 14,
  parameter int MAX_SCORE = 9999
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [SCORE_W-1:0] score,
  input  logic               new_score,
  output logic               busy,
  output logic [15:0]        bcd,
  output logic               bcd_valid,
  output logic [6:0]         hex3,
  output logic [6:0]         hex2,
  output logic [6:0]         hex1,
  output logic [6:0]         hex0,
  output logic [15:0]        hi_bcd,
  output logic               new_hi
);

  localparam int                 CNT_W   = $clog2(SCORE_W);
  localparam logic [SCORE_W-1:0] MAX_VAL = SCORE_W'(MAX_SCORE);
  localparam logic [CNT_W-1:0]   LAST_IT = CNT_W'(SCORE_W - 1);
  localparam logic [6:0]         SEG_ZERO = 7'h40;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nx;
  logic [SCORE_W-1:0] r_bin;
  logic [15:0]        r_scratch;
  logic [CNT_W-1:0]   r_count;
  logic               r_pending;
  logic [SCORE_W-1:0] r_pending_score;
  logic [15:0]        r_bcd;
  logic               r_bcd_valid;
  logic [6:0]         r_hex3;
  logic [6:0]         r_hex2;
  logic [6:0]         r_hex1;
  logic [6:0]         r_hex0;

  logic [15:0]        w_adj;
  logic [15:0]        w_scratch_nx;
  logic [SCORE_W-1:0] w_bin_nx;
  logic               w_restart;
  logic [SCORE_W-1:0] w_restart_val;

  // Saturate oversized scores so the four digits never overflow
  function automatic logic [SCORE_W-1:0] f_clamp(input logic [SCORE_W-1:0] v);
    return (v > MAX_VAL) ? MAX_VAL : v;
  endfunction

  // Active-low {g,f,e,d,c,b,a}; anything that is not a decimal digit shows blank
  function automatic logic [6:0] f_seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // A pulse arriving in the DONE cycle itself is newer than anything queued
  assign w_restart     = r_pending | new_score;
  assign w_restart_val = new_score ? score : r_pending_score;

  // One double-dabble step: add-3 on digits >= 5, then shift binary into scratch
  always_comb begin
    w_adj = r_scratch;
    for (int i = 0; i < 4; i++) begin
      if (r_scratch[4*i +: 4] >= 4'd5) begin
        w_adj[4*i +: 4] = r_scratch[4*i +: 4] + 4'd3;
      end
    end
    w_scratch_nx = {w_adj[14:0], r_bin[SCORE_W-1]};
    w_bin_nx     = {r_bin[SCORE_W-2:0], 1'b0};
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Next-state decode: load, SCORE_W shift iterations, publish, optional restart
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      IDLE:    if (new_score) w_state_nx = CONVERT;
      CONVERT: if (r_count == LAST_IT) w_state_nx = DONE;
      DONE:    w_state_nx = w_restart ? CONVERT : IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  // Conversion datapath, one-deep latest-wins queue, and registered display outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_bin           <= '0;
      r_scratch       <= '0;
      r_count         <= '0;
      r_pending       <= 1'b0;
      r_pending_score <= '0;
      r_bcd           <= '0;
      r_bcd_valid     <= 1'b0;
      r_hex3          <= SEG_ZERO;
      r_hex2          <= SEG_ZERO;
      r_hex1          <= SEG_ZERO;
      r_hex0          <= SEG_ZERO;
    end else begin
      r_bcd_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (new_score) begin
            r_bin     <= f_clamp(score);
            r_scratch <= '0;
            r_count   <= '0;
          end
        end
        CONVERT: begin
          r_scratch <= w_scratch_nx;
          r_bin     <= w_bin_nx;
          r_count   <= r_count + CNT_W'(1);
          if (new_score) begin
            r_pending       <= 1'b1;
            r_pending_score <= score;
          end
        end
        DONE: begin
          r_bcd       <= r_scratch;
          r_bcd_valid <= 1'b1;
          r_hex3      <= f_seg7(r_scratch[15:12]);
          r_hex2      <= f_seg7(r_scratch[11:8]);
          r_hex1      <= f_seg7(r_scratch[7:4]);
          r_hex0      <= f_seg7(r_scratch[3:0]);
          if (w_restart) begin
            r_bin     <= f_clamp(w_restart_val);
            r_scratch <= '0;
            r_count   <= '0;
            r_pending <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (r_state != IDLE);
  assign bcd       = r_bcd;
  assign bcd_valid = r_bcd_valid;
  assign hex3      = r_hex3;
  assign hex2      = r_hex2;
  assign hex1      = r_hex1;
  assign hex0      = r_hex0;

`ifdef HISCORE_EN
  logic [15:0] r_hi_bcd;
  logic        r_new_hi;

  // Track the best result; BCD packing preserves numeric order so a plain compare works
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_hi_bcd <= '0;
      r_new_hi <= 1'b0;
    end else begin
      r_new_hi <= 1'b0;
      if ((r_state == DONE) && (r_scratch > r_hi_bcd)) begin
        r_hi_bcd <= r_scratch;
        r_new_hi <= 1'b1;
      end
    end
  end

  assign hi_bcd = r_hi_bcd;
  assign new_hi = r_new_hi;
`else
  assign hi_bcd = 16'h0000;
  assign new_hi = 1'b0;
`endif

endmodule
